i2c_reg_controller: RTL and testbench

Protocol layer between the I2C bus interface and the LED controller's 8-entry register file. Consumes received bytes with START/STOP pulses, decodes the device address, control byte and data bytes, and issues register write/read strobes. Supports pointer auto-increment. Returns read data and per-byte ACK/NACK decisions to the bus interface.

---
 rtl/i2c_reg_controller.sv | 130 +++++++++++++
 tb/tb_i2c_reg_controller.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_controller.sv
// I2C protocol layer: decodes address/control/data bytes into register file
// write/read strobes with optional pointer auto-increment.
module i2c_reg_controller #(
  parameter logic [6:0] DEV_ADDR = 7'h60,
  parameter logic [7:0] AI_MASK  = 8'h80
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i2c_start,
  input  logic       i2c_stop,
  input  logic [7:0] i2c_byte,
  input  logic       i2c_byte_valid,
  input  logic       tx_req,
  output logic       ack_valid,
  output logic       ack,
  output logic [7:0] tx_byte,
  output logic       tx_valid,
  output logic [2:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_write,
  output logic       reg_read,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, ADDR, CTRL, WDATA, RDATA, IGNORE} state_t;

  state_t     state, state_nxt;
  logic       byte_ev, addr_hit, ctrl_ok;
  logic       ack_en, ack_nxt, ctrl_load, wr_en;
  logic [2:0] ptr;
  logic       ai;
  logic       rd_pend;

  // A byte coinciding with START or STOP is dropped outright.
  assign byte_ev  = i2c_byte_valid & ~i2c_start & ~i2c_stop;
  assign addr_hit = (i2c_byte[7:1] == DEV_ADDR);
  assign ctrl_ok  = ((i2c_byte & ~(AI_MASK | 8'h07)) == '0);

  always_comb begin
    state_nxt = state;
    ack_en    = 1'b0;
    ack_nxt   = 1'b0;
    ctrl_load = 1'b0;
    wr_en     = 1'b0;
    if (i2c_start) begin
      state_nxt = ADDR;
    end else if (i2c_stop) begin
      state_nxt = IDLE;
    end else if (byte_ev) begin
      case (state)
        ADDR: begin
          ack_en = 1'b1;
          if (addr_hit) begin
            ack_nxt   = 1'b1;
            state_nxt = i2c_byte[0] ? RDATA : CTRL;
          end else begin
            state_nxt = IGNORE;
          end
        end
        CTRL: begin
          ack_en = 1'b1;
          if (ctrl_ok) begin
            ack_nxt   = 1'b1;
            ctrl_load = 1'b1;
            state_nxt = WDATA;
          end else begin
            state_nxt = IGNORE;
          end
        end
        WDATA: begin
          ack_en  = 1'b1;
          ack_nxt = 1'b1;
          wr_en   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ack_valid <= 1'b0;
      ack       <= 1'b0;
      tx_byte   <= 8'hFF;
      tx_valid  <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_write <= 1'b0;
      reg_read  <= 1'b0;
      busy      <= 1'b0;
      ptr       <= '0;
      ai        <= 1'b0;
      rd_pend   <= 1'b0;
    end else begin
      ack_valid <= ack_en;
      if (ack_en) ack <= ack_nxt;
      reg_write <= wr_en;
      reg_read  <= 1'b0;
      busy      <= (state_nxt != IDLE);
      // Second read stage: reg_rdata is valid while reg_read is high.
      tx_valid  <= rd_pend;
      if (rd_pend) tx_byte <= reg_read ? reg_rdata : 8'hFF;
      rd_pend   <= 1'b0;
      if (tx_req && !rd_pend) begin
        rd_pend <= 1'b1;
        if (state == RDATA) begin
          reg_read <= 1'b1;
          reg_addr <= ptr;
          if (ai) ptr <= ptr + 3'd1;
        end
      end
      if (ctrl_load) begin
        ptr <= i2c_byte[2:0];
        ai  <= |(i2c_byte & AI_MASK);
      end
      if (wr_en) begin
        reg_addr  <= ptr;
        reg_wdata <= i2c_byte;
        if (ai) ptr <= ptr + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_i2c_reg_controller.sv
// Cycle-accurate check of i2c_reg_controller against a transaction-level model
// that tracks byte position within each I2C transfer.
module tb_i2c_reg_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       i2c_start = 1'b0, i2c_stop = 1'b0, i2c_byte_valid = 1'b0, tx_req = 1'b0;
  logic [7:0] i2c_byte = '0;
  logic       ack_valid, ack, tx_valid, reg_write, reg_read, busy;
  logic [7:0] tx_byte, reg_wdata, reg_rdata;
  logic [2:0] reg_addr;

  logic [7:0] rf [8];
  assign reg_rdata = rf[reg_addr];

  i2c_reg_controller #(.DEV_ADDR(7'h60), .AI_MASK(8'h80)) dut (
    .clk(clk), .reset(reset), .i2c_start(i2c_start), .i2c_stop(i2c_stop),
    .i2c_byte(i2c_byte), .i2c_byte_valid(i2c_byte_valid), .tx_req(tx_req),
    .ack_valid(ack_valid), .ack(ack), .tx_byte(tx_byte), .tx_valid(tx_valid),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_write(reg_write),
    .reg_read(reg_read), .reg_rdata(reg_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0, n_errors = 0;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: position k within the transfer (0 = address byte), direction,
  // whether the transfer was rejected, plus pointer and pending read.
  logic       m_in, m_rd, m_dead, m_ai, m_pend, m_pend_real;
  int         m_k;
  logic [2:0] m_ptr, m_pend_addr;
  logic       e_ack_valid, e_ack, e_tx_valid, e_reg_write, e_reg_read;
  logic [7:0] e_tx_byte, e_reg_wdata;
  logic [2:0] e_reg_addr;

  task automatic model_step();
    logic was_pend;
    if (reset) begin
      m_in = 0; m_rd = 0; m_dead = 0; m_ai = 0; m_pend = 0; m_pend_real = 0;
      m_k = 0; m_ptr = 0; m_pend_addr = 0;
      e_ack_valid = 0; e_ack = 0; e_tx_valid = 0; e_reg_write = 0; e_reg_read = 0;
      e_tx_byte = 8'hFF; e_reg_wdata = 0; e_reg_addr = 0;
      return;
    end
    e_ack_valid = 0; e_reg_write = 0; e_reg_read = 0; e_tx_valid = 0;
    was_pend = m_pend;
    m_pend = 0;
    if (was_pend) begin
      e_tx_valid = 1;
      e_tx_byte  = m_pend_real ? rf[m_pend_addr] : 8'hFF;
    end
    if (tx_req && !was_pend) begin
      m_pend = 1;
      m_pend_real = m_in && !m_dead && m_rd && m_k >= 1;
      if (m_pend_real) begin
        e_reg_read = 1; e_reg_addr = m_ptr; m_pend_addr = m_ptr;
        if (m_ai) m_ptr = m_ptr + 1;
      end
    end
    if (i2c_start) begin
      m_in = 1; m_k = 0; m_dead = 0;
    end else if (i2c_stop) begin
      m_in = 0;
    end else if (i2c_byte_valid && m_in && !m_dead) begin
      if (m_k == 0) begin
        e_ack_valid = 1;
        if (i2c_byte[7:1] == 7'h60) begin
          e_ack = 1; m_rd = i2c_byte[0]; m_k = 1;
        end else begin
          e_ack = 0; m_dead = 1;
        end
      end else if (m_rd) begin
        // master-side ACK of read data is not ours to answer
      end else if (m_k == 1) begin
        e_ack_valid = 1;
        if ((i2c_byte & 8'h78) == 0) begin
          e_ack = 1; m_ptr = i2c_byte[2:0]; m_ai = i2c_byte[7]; m_k = 2;
        end else begin
          e_ack = 0; m_dead = 1;
        end
      end else begin
        e_ack_valid = 1; e_ack = 1;
        e_reg_write = 1; e_reg_addr = m_ptr; e_reg_wdata = i2c_byte;
        if (m_ai) m_ptr = m_ptr + 1;
      end
    end
  endtask

  task automatic cyc(input logic r, input logic st, input logic sp,
                     input logic bv, input logic [7:0] b, input logic tq);
    reset = r; i2c_start = st; i2c_stop = sp; i2c_byte_valid = bv; i2c_byte = b; tx_req = tq;
    @(posedge clk);
    model_step();
    #1;
    check_eq("ack_valid", {7'd0, ack_valid}, {7'd0, e_ack_valid});
    check_eq("ack",       {7'd0, ack},       {7'd0, e_ack});
    check_eq("tx_valid",  {7'd0, tx_valid},  {7'd0, e_tx_valid});
    check_eq("tx_byte",   tx_byte,           e_tx_byte);
    check_eq("reg_write", {7'd0, reg_write}, {7'd0, e_reg_write});
    check_eq("reg_read",  {7'd0, reg_read},  {7'd0, e_reg_read});
    check_eq("reg_addr",  {5'd0, reg_addr},  {5'd0, e_reg_addr});
    check_eq("reg_wdata", reg_wdata,         e_reg_wdata);
    check_eq("busy",      {7'd0, busy},      {7'd0, m_in});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 8'h00, 0);
  endtask
  task automatic sb(input logic [7:0] b);
    cyc(0, 0, 0, 1, b, 0);
    idle(1);
  endtask
  task automatic start_c();
    cyc(0, 1, 0, 0, 8'h00, 0);
  endtask
  task automatic stop_c();
    cyc(0, 0, 1, 0, 8'h00, 0);
    idle(1);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rf[i] = 8'($urandom);
    rf[2] = 8'h5A; rf[3] = 8'h3C;
    cyc(1, 0, 0, 0, 8'h00, 0);
    cyc(1, 0, 0, 0, 8'h00, 0);
    idle(2);
    // auto-increment write
    start_c(); sb(8'hC0); sb(8'h80); sb(8'h11); sb(8'h22); sb(8'h33); stop_c();
    // pointer wrap
    start_c(); sb(8'hC0); sb(8'h87); sb(8'hAA); sb(8'hBB); stop_c();
    // no auto-increment
    start_c(); sb(8'hC0); sb(8'h05); sb(8'h01); sb(8'h02); stop_c();
    // address mismatch
    start_c(); sb(8'hC2); sb(8'h11); sb(8'h22); stop_c();
    // invalid control byte
    start_c(); sb(8'hC0); sb(8'h48); sb(8'h11); stop_c();
    // repeated-START read
    start_c(); sb(8'hC0); sb(8'h82); start_c(); sb(8'hC1);
    cyc(0, 0, 0, 0, 8'h00, 1); idle(3);
    cyc(0, 0, 0, 0, 8'h00, 1); idle(3);
    cyc(0, 0, 0, 0, 8'h00, 1); cyc(0, 0, 0, 0, 8'h00, 1); idle(3);
    stop_c();
    // tx_req outside a read
    cyc(0, 0, 0, 0, 8'h00, 1); idle(3);
    // reset on a data byte, then read from pointer 0
    start_c(); sb(8'hC0); sb(8'h80);
    cyc(1, 0, 0, 1, 8'h44, 0); idle(1);
    start_c(); sb(8'hC1); cyc(0, 0, 0, 0, 8'h00, 1); idle(3); stop_c();
    // start colliding with a byte, then stop colliding with a byte
    cyc(0, 1, 0, 1, 8'hC0, 0); idle(1); sb(8'hC0);
    cyc(0, 0, 1, 1, 8'h81, 0); idle(2);
    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      logic [7:0] b;
      case ($urandom_range(0, 7))
        0, 1:    b = 8'hC0;
        2:       b = 8'hC1;
        3, 4:    b = 8'(($urandom_range(0, 1) << 7) | $urandom_range(0, 7));
        default: b = 8'($urandom);
      endcase
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 19) == 0),
          ($urandom_range(0, 24) == 0), ($urandom_range(0, 2) == 0), b,
          ($urandom_range(0, 5) == 0));
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
